sp_ram_rr_arbiter: RTL and testbench

//  Shares one single-port RAM (1-cycle read latency, byte enables) between NUM_PORTS requesters.

---
 rtl/sp_ram_arb_pkg.sv | 38 +++
 rtl/sp_ram_rr_arbiter_core.sv | 80 ++++++++
 rtl/sp_ram_rr_arbiter.sv | 88 ++++++++
 tb/tb_sp_ram_rr_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sp_ram_arb_pkg.sv
// Shared types and the round-robin pick function for the single-port RAM arbiter.
package sp_ram_arb_pkg;

    // Widest arbiter supported; cores must instantiate with fewer ports than this.
    localparam int MAX_PORTS = 32;

    typedef logic [$clog2(MAX_PORTS)-1:0] port_idx_t;
    typedef logic [7:0]                   lock_cnt_t;

    // First requesting port at or after prio, wrapping modulo n; one-hot result.
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input port_idx_t            prio,
        input int                   n
    );
        logic [MAX_PORTS-1:0] gnt;
        logic                 found;
        int                   idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            idx = int'(prio) + i;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((i < n) && !found && req[port_idx_t'(idx)]) begin
                gnt[port_idx_t'(idx)] = 1'b1;
                found                 = 1'b1;
            end else begin
                found = found;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/sp_ram_rr_arbiter_core.sv
// Round-robin grant core with a bounded lock that lets one port keep the RAM for bursts.
module rr_arb_core
    import sp_ram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int MAX_LOCK  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] lock_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output port_idx_t            gnt_idx_o
);

    localparam lock_cnt_t LOCK_LIM  = lock_cnt_t'(MAX_LOCK - 1);
    localparam port_idx_t LAST_PORT = port_idx_t'(NUM_PORTS - 1);

    port_idx_t            prio_q;
    port_idx_t            prio_nxt_s;
    lock_cnt_t            lock_cnt_q;
    lock_cnt_t            lock_cnt_nxt_s;
    logic [MAX_PORTS-1:0] req_ext_s;
    logic [MAX_PORTS-1:0] pick_s;
    logic                 illegal_s;
    logic [NUM_PORTS-1:0] gnt_s;
    port_idx_t            idx_s;
    logic                 any_gnt_s;
    logic                 lock_sel_s;

    // Grant selection; pick bits beyond NUM_PORTS can never be set and suppress the grant if they were.
    always_comb begin
        req_ext_s                = '0;
        req_ext_s[NUM_PORTS-1:0] = req_i;
        pick_s                   = rr_pick(req_ext_s, prio_q, NUM_PORTS);
        illegal_s                = |pick_s[MAX_PORTS-1:NUM_PORTS];
        if (rst_i || illegal_s) begin
            gnt_s = '0;
        end else begin
            gnt_s = pick_s[NUM_PORTS-1:0];
        end
        idx_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            idx_s = idx_s | (gnt_s[p] ? port_idx_t'(p) : port_idx_t'(0));
        end
        any_gnt_s  = |gnt_s;
        lock_sel_s = |(gnt_s & lock_i);
    end

    // Next priority/lock count: lock keeps priority until the count reaches its limit.
    always_comb begin
        prio_nxt_s     = prio_q;
        lock_cnt_nxt_s = lock_cnt_q;
        if (!any_gnt_s) begin
            prio_nxt_s     = prio_q;
            lock_cnt_nxt_s = lock_cnt_q;
        end else if (lock_sel_s && (lock_cnt_q < LOCK_LIM)) begin
            prio_nxt_s     = idx_s;
            lock_cnt_nxt_s = lock_cnt_q + lock_cnt_t'(1);
        end else begin
            prio_nxt_s     = (idx_s == LAST_PORT) ? port_idx_t'(0) : idx_s + port_idx_t'(1);
            lock_cnt_nxt_s = lock_cnt_t'(0);
        end
    end

    // Priority and lock count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q     <= port_idx_t'(0);
            lock_cnt_q <= lock_cnt_t'(0);
        end else begin
            prio_q     <= prio_nxt_s;
            lock_cnt_q <= lock_cnt_nxt_s;
        end
    end

    assign gnt_o     = gnt_s;
    assign gnt_idx_o = idx_s;

endmodule

// File: rtl/sp_ram_rr_arbiter.sv
// Shares one single-port RAM between NUM_PORTS requesters; responses return to the granted port.
module sp_ram_rr_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 4,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_PORTS-1:0]            req_i,
    input  logic [NUM_PORTS-1:0]            lock_i,
    input  logic [NUM_PORTS-1:0]            we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]   be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]            gnt_o,
    output logic [NUM_PORTS-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            mem_req_o,
    output logic                            mem_we_o,
    output logic [ADDR_WIDTH-1:0]           mem_addr_o,
    output logic [BE_WIDTH-1:0]             mem_be_o,
    output logic [DATA_WIDTH-1:0]           mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]           mem_rdata_i
);

    logic [NUM_PORTS-1:0]  gnt_s;
    port_idx_t             gnt_idx_s;
    logic                  any_gnt_s;
    logic [NUM_PORTS-1:0]  sel_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [BE_WIDTH-1:0]   mem_be_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic [NUM_PORTS-1:0]  rvalid_r;

    rr_arb_core #(
        .NUM_PORTS (NUM_PORTS),
        .MAX_LOCK  (MAX_LOCK)
    ) u_core (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .lock_i    (lock_i),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s)
    );

    // Field mux: AND-OR of the selected port so idle cycles drive all-zero memory fields.
    always_comb begin
        any_gnt_s   = |gnt_s;
        sel_s       = '0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_be_s    = '0;
        mem_wdata_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            sel_s[p]    = any_gnt_s && (gnt_idx_s == port_idx_t'(p));
            mem_we_s    = mem_we_s | (we_i[p] & sel_s[p]);
            mem_addr_s  = mem_addr_s  | (addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]  & {ADDR_WIDTH{sel_s[p]}});
            mem_be_s    = mem_be_s    | (be_i[p*BE_WIDTH +: BE_WIDTH]        & {BE_WIDTH{sel_s[p]}});
            mem_wdata_s = mem_wdata_s | (wdata_i[p*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_s[p]}});
        end
    end

    // Response valid tracks the grant with the RAM's one-cycle latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_r <= '0;
        end else begin
            rvalid_r <= gnt_s;
        end
    end

    // Masking with rst_i drops a response that is in flight when reset arrives.
    assign rvalid_o    = rvalid_r & {NUM_PORTS{~rst_i}};
    assign rdata_o     = mem_rdata_i;
    assign gnt_o       = gnt_s;
    assign mem_req_o   = any_gnt_s;
    assign mem_we_o    = mem_we_s;
    assign mem_addr_o  = mem_addr_s;
    assign mem_be_o    = mem_be_s;
    assign mem_wdata_o = mem_wdata_s;

endmodule

// File: tb/tb_sp_ram_rr_arbiter.sv
// Table-driven bench with a RAM model and a response scoreboard for sp_ram_rr_arbiter.
module tb_sp_ram_rr_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int ML = 4;

    logic            clk;
    logic            rst_i;
    logic [NP-1:0]   req_i, lock_i, we_i;
    logic [NP*AW-1:0] addr_i;
    logic [NP*BW-1:0] be_i;
    logic [NP*DW-1:0] wdata_i;
    logic [NP-1:0]   gnt_o, rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            mem_req_o, mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [BW-1:0]   mem_be_o;
    logic [DW-1:0]   mem_wdata_o;
    logic [DW-1:0]   mem_rdata_i;

    sp_ram_rr_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .lock_i(lock_i), .we_i(we_i),
        .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with byte enables and one-cycle read latency.
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be_o[b]) ram[mem_addr_o[9:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
            end else begin
                mem_rdata_i <= ram[mem_addr_o[9:2]];
            end
        end
    end

    typedef struct {
        logic             rst;
        logic [1:0]       req, lock, we;
        logic [1:0][31:0] addr;
        logic [1:0][3:0]  be;
        logic [1:0][31:0] wdata;
        logic [1:0]       exp_gnt;
    } vec_t;

    typedef struct {
        logic [1:0]  rv;
        logic        rd;
        logic [31:0] data;
    } resp_t;

    vec_t        vecs[$];
    resp_t       sb[$];
    logic [31:0] ref_mem [0:255];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic [1:0] lock,
                                input logic [1:0] we, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [3:0] b0, input logic [3:0] b1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] eg);
        vec_t v;
        v.rst = rst; v.req = req; v.lock = lock; v.we = we;
        v.addr[0] = a0; v.addr[1] = a1; v.be[0] = b0; v.be[1] = b1;
        v.wdata[0] = d0; v.wdata[1] = d1; v.exp_gnt = eg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        resp_t r;
        int    p;
        rst_i = v.rst; req_i = v.req; lock_i = v.lock; we_i = v.we;
        addr_i = v.addr; be_i = v.be; wdata_i = v.wdata;
        #1;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("rvalid", {30'd0, rvalid_o}, {30'd0, r.rv & ~{2{v.rst}}});
            if (r.rd && !v.rst) chk("rdata", rdata_o, r.data);
        end
        @(negedge clk);
        p = v.exp_gnt[1] ? 1 : 0;
        chk("gnt", {30'd0, gnt_o}, {30'd0, v.exp_gnt});
        chk("mem_req", {31'd0, mem_req_o}, {31'd0, |v.exp_gnt});
        chk("mem_we", {31'd0, mem_we_o}, (v.exp_gnt != 2'b00) ? {31'd0, v.we[p]} : 32'd0);
        chk("mem_addr", mem_addr_o, (v.exp_gnt != 2'b00) ? v.addr[p] : 32'd0);
        chk("mem_be", {28'd0, mem_be_o}, (v.exp_gnt != 2'b00) ? {28'd0, v.be[p]} : 32'd0);
        chk("mem_wdata", mem_wdata_o, (v.exp_gnt != 2'b00) ? v.wdata[p] : 32'd0);
        r.rv = v.exp_gnt; r.rd = 1'b0; r.data = 32'd0;
        if (v.exp_gnt != 2'b00) begin
            if (v.we[p]) begin
                for (int b = 0; b < 4; b++)
                    if (v.be[p][b]) ref_mem[v.addr[p][9:2]][b*8 +: 8] = v.wdata[p][b*8 +: 8];
            end else begin
                r.rd = 1'b1;
                r.data = ref_mem[v.addr[p][9:2]];
            end
        end
        sb.push_back(r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] adr_tab [4];
        adr_tab[0] = 32'h10; adr_tab[1] = 32'h20; adr_tab[2] = 32'h30; adr_tab[3] = 32'h40;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        mem_rdata_i = 32'd0;
        rst_i = 1'b1; req_i = 2'b00; lock_i = 2'b00; we_i = 2'b00;
        addr_i = '0; be_i = '0; wdata_i = '0;

        // reset, then port0 write/read and partial-byte write over it
        vecs.push_back(mk(1'b1, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 4'hF, 4'hF, 32'h0, 32'h0, 2'b00));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 2'b01, 32'h10, 32'h0, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 2'b01));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 4'hF, 4'h0, 32'h0, 32'h0, 2'b01));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 2'b01, 32'h10, 32'h0, 4'h2, 4'h0, 32'h0000AB00, 32'h0, 2'b01));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 4'hF, 4'h0, 32'h0, 32'h0, 2'b01));
        // idle: memory fields zero, priority (now port1) held
        vecs.push_back(mk(1'b0, 2'b00, 2'b11, 2'b11, 32'h10, 32'h20, 4'hF, 4'hF, 32'h5, 32'h6, 2'b00));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 2'b00, 32'h10, 32'h10, 4'hF, 4'h3, 32'h0, 32'h0, 2'b10));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 2'b00, 32'h10, 32'h10, 4'hF, 4'h3, 32'h0, 32'h0, 2'b01));
        // reset right after a grant drops its response and restores port0 priority
        vecs.push_back(mk(1'b1, 2'b11, 2'b00, 2'b00, 32'h10, 32'h10, 4'hF, 4'hF, 32'h0, 32'h0, 2'b00));
        foreach (vecs[i]) apply_vec(vecs[i]);
        vecs.delete();

        // back-to-back contention from reset: strict alternation, random traffic
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(1'b0, 2'b11, 2'b00, 2'($urandom_range(0, 3)),
                              adr_tab[$urandom_range(0, 3)], adr_tab[$urandom_range(0, 3)],
                              4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)),
                              $urandom, $urandom, (i % 2 == 0) ? 2'b01 : 2'b10));
        end
        // bounded lock: port1 alone then contended, four grants total, then port0
        vecs.push_back(mk(1'b0, 2'b10, 2'b10, 2'b10, 32'h20, 32'h20, 4'hF, 4'hF, 32'h0, 32'hCAFEF00D, 2'b10));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b0, 2'b11, 2'b10, 2'b10, 32'h20, 32'h20, 4'hF, 4'hF, 32'h0, 32'hCAFEF00D, 2'b10));
        vecs.push_back(mk(1'b0, 2'b11, 2'b10, 2'b10, 32'h20, 32'h20, 4'hF, 4'hF, 32'h0, 32'hCAFEF00D, 2'b01));
        vecs.push_back(mk(1'b0, 2'b11, 2'b10, 2'b00, 32'h20, 32'h10, 4'hF, 4'hF, 32'h0, 32'h0, 2'b10));
        // lone requester with lock beyond the limit keeps winning
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 32'h20, 32'h0, 4'hF, 4'h0, 32'h0, 32'h0, 2'b01));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00));
        foreach (vecs[i]) apply_vec(vecs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
